asrv32_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the asrv32 core. It sits beside the base ALU in the Execute stage. It accepts one operation per start pulse, computes it over a fixed number of cycles with a shift-add / restoring-divide datapath, and returns a registered result with a one-cycle done pulse. The stage controller stalls on `o_busy`.

---
 rtl/asrv32_muldiv.sv | 180 ++++++++++++++++++
 tb/tb_asrv32_muldiv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asrv32_muldiv.sv
// asrv32_muldiv: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle over XLEN cycles.
// A registered result comes back with a one-cycle done pulse.
module asrv32_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned   CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_b;        // multiplicand (mul) or divisor (div), absolute value
  logic [2*XLEN-1:0] r_acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]     r_cnt;
  logic              r_neg_q;    // product / quotient must be negated
  logic              r_neg_r;    // remainder must be negated
  logic              r_special;
  logic [XLEN-1:0]   r_spec_res;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  // Operand decode at start
  logic              w_accept;
  logic              w_is_div;
  logic              w_sgn1;
  logic              w_sgn2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_spec_res;

  // Iteration datapath
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nx;

  // Final result shaping
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fin;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
  assign w_is_div = i_op[2];

  // Operand signedness, absolute values and special-case detection
  always_comb begin
    w_sgn1     = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
    w_sgn2     = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
    w_neg1     = w_sgn1 && i_op1[XLEN-1];
    w_neg2     = w_sgn2 && i_op2[XLEN-1];
    w_abs1     = w_neg1 ? (~i_op1 + 1'b1) : i_op1;
    w_abs2     = w_neg2 ? (~i_op2 + 1'b1) : i_op2;
    w_div0     = w_is_div && (i_op2 == '0);
    w_ovf      = w_is_div && !i_op[0] && (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op2 == '1);
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = i_op[1] ? i_op1 : '1;
    else if (w_ovf)
      w_spec_res = i_op[1] ? '0 : i_op1;
  end

  // One shift-add step and one restoring-divide step
  always_comb begin
    w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_shift  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge     = (w_shift >= {1'b0, r_b});
    // Partial remainder stays below the divisor, so the difference fits in XLEN bits
    w_rem_nx = w_ge ? (w_shift[XLEN-1:0] - r_b) : w_shift[XLEN-1:0];
  end

  // Sign correction and result selection for FIN
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_acc[XLEN-1:0];
    w_rem  = r_acc[2*XLEN-1:XLEN];
    w_fin  = '0;
    if (r_special)
      w_fin = r_spec_res;
    else if (!r_op[2])
      w_fin = (r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (r_op[1])
      w_fin = r_neg_r ? (~w_rem + 1'b1) : w_rem;
    else
      w_fin = r_neg_q ? (~w_quo + 1'b1) : w_quo;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // FSM next-state and busy output
  always_comb begin
    w_next = r_state;
    o_busy = (r_state != S_IDLE);
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) w_next = (w_div0 || w_ovf) ? S_FIN : S_CALC;
        S_CALC: if (r_cnt == LAST) w_next = S_FIN;
        S_FIN:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Operand latch and per-cycle iteration
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
    end else if (w_accept) begin
      r_op       <= i_op;
      r_b        <= w_is_div ? w_abs2 : w_abs1;
      r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
      r_cnt      <= '0;
      r_neg_q    <= w_neg1 ^ w_neg2;
      r_neg_r    <= w_neg1;
      r_special  <= w_div0 || w_ovf;
      r_spec_res <= w_spec_res;
    end else if ((r_state == S_CALC) && !i_flush) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op[2])
        r_acc <= {w_rem_nx, r_acc[XLEN-2:0], w_ge};
      else
        r_acc <= {w_sum, r_acc[XLEN-1:1]};
    end
  end

  // Result register and done pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN) && !i_flush;
      if ((r_state == S_FIN) && !i_flush)
        r_result <= w_fin;
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_asrv32_muldiv.sv
// Self-checking bench for asrv32_muldiv with directed and random stimulus
// against a plain-arithmetic RV32M reference model.
module tb_asrv32_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  asrv32_muldiv #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_flush  (flush),
    .i_op     (op),
    .i_op1    (a),
    .i_op2    (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  // RV32M reference model using 64-bit and native signed arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] fop, input logic [31:0] x,
                                             input logic [31:0] y);
    longint px, py, prod;
    int     sx, sy;
    logic [63:0] p;
    px   = (fop == 3'd1 || fop == 3'd2) ? longint'($signed(x)) : longint'({32'b0, x});
    py   = (fop == 3'd1) ? longint'($signed(y)) : longint'({32'b0, y});
    prod = px * py;
    p    = prod;
    sx   = $signed(x);
    sy   = $signed(y);
    case (fop)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return sx / sy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] fop, input logic [31:0] x, input logic [31:0] y);
    if (fop[2] && (y == 0)) return 1;
    if ((fop == 3'd4 || fop == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation and wait (bounded) for done; lat = edges after the start edge, -1 on timeout
  task automatic do_op(input logic [2:0] fop, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    op = fop; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    int l;
    start = 0; flush = 0; op = 0; a = 0; b = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 32'd5, 32'd5, r, l);
    checks++; if (r !== 32'd25) begin errors++; $display("FAIL mul_5x5: got %h expected %h", r, 32'd25); end
    // DIVU 100/7 then asynchronous reset in the middle of CALC
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy: got %b expected 1", busy); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd4, r, l);
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL mul_3x4: got %h expected %h", r, 32'd12); end
    checks++; if (l !== 33) begin errors++; $display("FAIL mul_3x4_lat: got %0d expected 33", l); end
  endtask

  task automatic test_mul_corner;
    logic [31:0] exp_tab [4];
    logic [31:0] r;
    int l;
    exp_tab[0] = 32'h0000_0001;
    exp_tab[1] = 32'h0000_0000;
    exp_tab[2] = 32'hFFFF_FFFF;
    exp_tab[3] = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      do_op(3'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l);
      checks++; if (r !== exp_tab[i]) begin errors++; $display("FAIL mul_ones op%0d: got %h expected %h", i, r, exp_tab[i]); end
      checks++; if (l !== 33) begin errors++; $display("FAIL mul_ones_lat op%0d: got %0d expected 33", i, l); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse op%0d: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_div_basic;
    logic [2:0]  ops [4];
    logic [31:0] xs [4], ys [4], es [4];
    logic [31:0] r;
    int l;
    ops[0] = 3'd4; xs[0] = 32'hFFFF_FFF9; ys[0] = 32'd2;  es[0] = 32'hFFFF_FFFD;
    ops[1] = 3'd6; xs[1] = 32'hFFFF_FFF9; ys[1] = 32'd2;  es[1] = 32'hFFFF_FFFF;
    ops[2] = 3'd5; xs[2] = 32'd100;       ys[2] = 32'd7;  es[2] = 32'd14;
    ops[3] = 3'd7; xs[3] = 32'd100;       ys[3] = 32'd7;  es[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], xs[i], ys[i], r, l);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL div_basic %0d: got %h expected %h", i, r, es[i]); end
      checks++; if (l !== 33) begin errors++; $display("FAIL div_basic_lat %0d: got %0d expected 33", i, l); end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops [6];
    logic [31:0] xs [6], ys [6], es [6];
    logic [31:0] r;
    int l;
    ops[0] = 3'd4; xs[0] = 32'd5;          ys[0] = 32'd0;          es[0] = 32'hFFFF_FFFF;
    ops[1] = 3'd6; xs[1] = 32'd5;          ys[1] = 32'd0;          es[1] = 32'd5;
    ops[2] = 3'd4; xs[2] = 32'h8000_0000;  ys[2] = 32'hFFFF_FFFF;  es[2] = 32'h8000_0000;
    ops[3] = 3'd6; xs[3] = 32'h8000_0000;  ys[3] = 32'hFFFF_FFFF;  es[3] = 32'h0;
    ops[4] = 3'd5; xs[4] = 32'h1234_5678;  ys[4] = 32'd0;          es[4] = 32'hFFFF_FFFF;
    ops[5] = 3'd7; xs[5] = 32'h1234_5678;  ys[5] = 32'd0;          es[5] = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], xs[i], ys[i], r, l);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL special %0d: got %h expected %h", i, r, es[i]); end
      checks++; if (l !== 1) begin errors++; $display("FAIL special_lat %0d: got %0d expected 1", i, l); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] r;
    int l;
    bit seen;
    do_op(3'd0, 32'd9, 32'd9, r, l);
    checks++; if (r !== 32'd81) begin errors++; $display("FAIL flush_prior: got %h expected %h", r, 32'd81); end
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b expected 0", busy); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_nodone: got %b expected 0", seen); end
    checks++; if (result !== 32'd81) begin errors++; $display("FAIL flush_result: got %h expected %h", result, 32'd81); end
    // start and flush together: nothing accepted
    @(negedge clk);
    op = 3'd4; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startflush_busy: got %b expected 0", busy); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL startflush_nodone: got %b expected 0", seen); end
    checks++; if (result !== 32'd81) begin errors++; $display("FAIL startflush_result: got %h expected %h", result, 32'd81); end
  endtask

  task automatic test_back_to_back;
    int l1, l2;
    logic [31:0] r1, r2;
    @(negedge clk);
    op = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l1 = -1; r1 = 32'hDEAD_BEEF;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      // ignored start pulses while busy, with an op that would finish in one edge
      start = (n >= 5 && n <= 8);
      if (start) begin op = 3'd5; a = 32'd1; b = 32'd0; end
      if (done) begin l1 = n; r1 = result; break; end
    end
    checks++; if (r1 !== 32'd42) begin errors++; $display("FAIL b2b_first: got %h expected %h", r1, 32'd42); end
    checks++; if (l1 !== 33) begin errors++; $display("FAIL b2b_first_lat: got %0d expected 33", l1); end
    // new start in the cycle done is high
    op = 3'd3; a = 32'h8000_0000; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    l2 = -1; r2 = 32'hDEAD_BEEF;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = (n >= 10 && n <= 12);
      if (start) begin op = 3'd7; a = 32'd9; b = 32'd0; end
      if (done) begin l2 = n; r2 = result; break; end
    end
    start = 1'b0;
    checks++; if (r2 !== 32'd2) begin errors++; $display("FAIL b2b_second: got %h expected %h", r2, 32'd2); end
    checks++; if (l2 !== 33) begin errors++; $display("FAIL b2b_second_lat: got %0d expected 33", l2); end
  endtask

  task automatic test_random;
    logic [2:0]  fop;
    logic [31:0] x, y, r, e;
    int l, el;
    for (int i = 0; i < 60; i++) begin
      fop = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'hFFFF_FFFF;
        default: ;
      endcase
      e  = ref_result(fop, x, y);
      el = ref_lat(fop, x, y);
      do_op(fop, x, y, r, l);
      checks++; if (r !== e) begin errors++; $display("FAIL random %0d op%0d %h,%h: got %h expected %h", i, fop, x, y, r, e); end
      checks++; if (l !== el) begin errors++; $display("FAIL random_lat %0d op%0d: got %0d expected %0d", i, fop, l, el); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_corner();
    test_div_basic();
    test_special();
    test_flush();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
